// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : RV32I integer register file with two combinational read ports and
//            one write port. After reset it clears x1..x31 and holds init_busy
//            high until the clear is done. Optional macro REGFILE_WRITE_BYPASS_EN
//            forwards a same-cycle write to any read port that addresses it.
// Revision : 1.0  initial release
// ============================================================================
module register_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            write_enable,
   input  logic [4:0]      write_addr,
   input  logic [XLEN-1:0] write_value,
   input  logic [4:0]      read_addr_1,
   input  logic [4:0]      read_addr_2,
   output logic [XLEN-1:0] read_value_1,
   output logic [XLEN-1:0] read_value_2,
   output logic            init_busy
);

   localparam logic [0:0] c_ST_CLEAR = 1'b0;
   localparam logic [0:0] c_ST_READY = 1'b1;
   localparam logic [4:0] c_LAST_IDX = 5'd31;
   localparam logic [4:0] c_ZERO_ADR = 5'd0;

   logic [0:0]      r_state;
   logic [4:0]      r_clear_idx;
   // x0 is hardwired to zero, so only x1..x31 have storage.
   logic [XLEN-1:0] r_regs [1:NREGS-1];

   logic            w_ready;
   logic            w_wr_valid;
   logic            w_bypass_1;
   logic            w_bypass_2;

   assign w_ready    = (r_state == c_ST_READY);
   assign w_wr_valid = w_ready && write_enable && (write_addr != c_ZERO_ADR);
   assign init_busy  = ~w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_CLEAR;
         r_clear_idx <= 5'd1;
      end else if (r_state == c_ST_CLEAR) begin
         if (r_clear_idx == c_LAST_IDX) begin
            r_state <= c_ST_READY;
         end else begin
            r_clear_idx <= r_clear_idx + 5'd1;
         end
      end
   end

   // Storage has no reset; the clear sequence zeroes it instead.
   always_ff @(posedge clk) begin
      if (r_state == c_ST_CLEAR) begin
         r_regs[r_clear_idx] <= '0;
      end else if (w_wr_valid) begin
         r_regs[write_addr] <= write_value;
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   assign w_bypass_1 = w_wr_valid && (write_addr == read_addr_1);
   assign w_bypass_2 = w_wr_valid && (write_addr == read_addr_2);
`else
   assign w_bypass_1 = 1'b0;
   assign w_bypass_2 = 1'b0;
`endif

   always_comb begin
      read_value_1 = '0;
      if (w_ready && (read_addr_1 != c_ZERO_ADR)) begin
         if (w_bypass_1) begin
            read_value_1 = write_value;
         end else begin
            read_value_1 = r_regs[read_addr_1];
         end
      end
   end

   always_comb begin
      read_value_2 = '0;
      if (w_ready && (read_addr_2 != c_ZERO_ADR)) begin
         if (w_bypass_2) begin
            read_value_2 = write_value;
         end else begin
            read_value_2 = r_regs[read_addr_2];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Scoreboard bench for register_file; a reference model predicts the
//            read ports and init_busy each cycle, a monitor checks them.
// Revision : 1.0  initial release
// ============================================================================
module tb_register_file;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            write_enable = 1'b0;
   logic [4:0]      write_addr = '0;
   logic [XLEN-1:0] write_value = '0;
   logic [4:0]      read_addr_1 = '0;
   logic [4:0]      read_addr_2 = '0;
   logic [XLEN-1:0] read_value_1;
   logic [XLEN-1:0] read_value_2;
   logic            init_busy;

   register_file #(.XLEN(XLEN), .NREGS(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_value  (write_value),
      .read_addr_1  (read_addr_1),
      .read_addr_2  (read_addr_2),
      .read_value_1 (read_value_1),
      .read_value_2 (read_value_2),
      .init_busy    (init_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            busy;
      logic [XLEN-1:0] v1;
      logic [XLEN-1:0] v2;
   } exp_t;

   exp_t            exp_q[$];
   logic [XLEN-1:0] model [32];
   int              edges_since_release = 0;
   bit              in_reset = 1'b1;
   int              n_compared = 0;
   int              n_mismatched = 0;

   function automatic bit model_busy();
      return in_reset || (edges_since_release < 31);
   endfunction

   function automatic logic [XLEN-1:0] model_read(input logic [4:0] a);
      if (model_busy() || a == 5'd0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (write_enable && write_addr != 5'd0 && write_addr == a) return write_value;
`endif
      return model[a];
   endfunction

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus: apply inputs, predict outputs, then advance the model past the edge.
   task automatic drive(input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wv,
                        input logic [4:0] ra1, input logic [4:0] ra2);
      exp_t e;
      write_enable = we;
      write_addr   = wa;
      write_value  = wv;
      read_addr_1  = ra1;
      read_addr_2  = ra2;
      e.busy = model_busy();
      e.v1   = model_read(ra1);
      e.v2   = model_read(ra2);
      exp_q.push_back(e);
      @(posedge clk);
      if (!in_reset) begin
         if (!model_busy() && we && wa != 5'd0) model[wa] = wv;
         edges_since_release++;
      end
      #1;
   endtask

   // Reset, then run the clear sequence; abort_after >= 0 stops it early.
   task automatic reset_and_clear(input int abort_after);
      int n;
      rst_n    = 1'b0;
      in_reset = 1'b1;
      edges_since_release = 0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      drive(1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      rst_n    = 1'b1;
      in_reset = 1'b0;
      n = 0;
      while (init_busy && n < 100) begin
         if (abort_after >= 0 && n == abort_after) return;
         if (n == 9)
            drive(1'b1, 5'd7, 32'hAAAA5555, 5'($urandom), 5'($urandom));
         else
            drive(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
         n++;
      end
      check("clear_edge_count", XLEN'(n), XLEN'(31));
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("init_busy",    XLEN'(init_busy), XLEN'(e.busy));
         check("read_value_1", read_value_1, e.v1);
         check("read_value_2", read_value_2, e.v2);
      end
   end

   initial begin
      logic [4:0] ra;
      @(posedge clk);
      #1;

      reset_and_clear(14);
      reset_and_clear(-1);

      for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, '0, 5'(i), 5'(31 - i));

      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      drive(1'b0, 5'd0, '0, 5'd5, 5'd5);
      drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
      drive(1'b0, 5'd0, '0, 5'd7, 5'd7);

      drive(1'b1, 5'd3, 32'h11, 5'd0, 5'd3);
      drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
      drive(1'b0, 5'd0, '0, 5'd3, 5'd3);

      for (int i = 0; i < 400; i++) begin
         ra = 5'($urandom);
         drive(1'($urandom), 5'($urandom), $urandom, ra,
               ($urandom_range(3) == 0) ? ra : 5'($urandom));
      end

      reset_and_clear(-1);
      for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, '0, 5'(i), 5'(i));

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      check("scoreboard_drained", XLEN'(exp_q.size()), XLEN'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
